// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the pipelined tree multiplier:
//   - LEGAL_WIDTH_MASK / width_is_legal : legal operand widths (4, 8, 16, 32)
//   - levels_of / lat_of                : adder-tree depth and pipeline latency
//   - level_offset                      : where tree level k starts in the flat
//                                         node vector (level 0 = partial products)
//   - stage_ctl_t                       : per-stage record header (valid + signed
//                                         flag). The sums of each stage travel
//                                         beside it as a packed array whose row
//                                         count halves at every level.
// -----------------------------------------------------------------------------
package mult_pkg;

    // Bit w is set when w is a legal operand width.
    localparam logic [32:0] LEGAL_WIDTH_MASK =
        (33'd1 << 4) | (33'd1 << 8) | (33'd1 << 16) | (33'd1 << 32);

    function automatic bit width_is_legal(input int w);
        bit ok;
        ok = 1'b0;
        if (w >= 0 && w <= 32) begin
            ok = LEGAL_WIDTH_MASK[w];
        end
        return ok;
    endfunction

    function automatic int levels_of(input int w);
        return $clog2(w);
    endfunction

    // Stage 0 plus one register per tree level.
    function automatic int lat_of(input int w);
        return $clog2(w) + 1;
    endfunction

    // Level k holds (w >> k) rows; levels are packed back to back starting at 0.
    function automatic int level_offset(input int w, input int k);
        return 2 * w - 2 * (w >> k);
    endfunction

    typedef struct packed {
        logic valid;
        logic sgn;
    } stage_ctl_t;

endpackage

// File: rtl/mult_add_level.sv
// -----------------------------------------------------------------------------
// mult_add_level
// One registered level of the pairwise adder tree. Row i of the output is
// sums_i[2i] + sums_i[2i+1]. Everything holds while en_i is low.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears ctl only)
//   en_i           global pipeline advance
//   ctl_i, sums_i  previous stage record (N_IN rows of PW bits)
//   ctl_o, sums_o  this stage record (N_IN/2 rows of PW bits)
// -----------------------------------------------------------------------------
module mult_add_level
    import mult_pkg::*;
#(
    parameter int PW   = 32,
    parameter int N_IN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  stage_ctl_t                 ctl_i,
    input  logic [N_IN-1:0][PW-1:0]    sums_i,
    output stage_ctl_t                 ctl_o,
    output logic [N_IN/2-1:0][PW-1:0]  sums_o
);

    localparam int N_OUT = N_IN / 2;

    stage_ctl_t                ctl_q;
    logic [N_OUT-1:0][PW-1:0]  sums_d;
    logic [N_OUT-1:0][PW-1:0]  sums_q;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
        assign sums_d[gi] = sums_i[2*gi] + sums_i[2*gi+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
        end else if (en_i) begin
            ctl_q <= ctl_i;
        end
    end

    // Data needs no reset: it is only looked at when the matching valid is set.
    always_ff @(posedge clk) begin
        if (en_i && ctl_i.valid) begin
            sums_q <= sums_d;
        end
    end

    assign ctl_o  = ctl_q;
    assign sums_o = sums_q;

endmodule

// File: rtl/pipelined_tree_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_tree_multiplier
// Full-precision WIDTH x WIDTH multiplier, signed or unsigned per transaction.
// Stage 0 registers WIDTH shifted partial products; a log2(WIDTH)-deep tree of
// registered pairwise adders reduces them; an output register holds the result.
// Latency LAT = $clog2(WIDTH)+1 cycles, one result per cycle, global stall.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready = pipeline advance)
//   in_signed             1 = two's-complement, 0 = unsigned (travels with data)
//   a, b                  operands (WIDTH bits)
//   out_valid/out_ready   result handshake
//   product               full 2*WIDTH-bit product
//   q                     only when MULT_ROUND_EN is defined: WIDTH-bit result,
//                         Q(WIDTH-1) rounded/saturated (signed) or the upper
//                         half of the product (unsigned)
// -----------------------------------------------------------------------------
module pipelined_tree_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
`ifdef MULT_ROUND_EN
    ,
    output logic [WIDTH-1:0]     q
`endif
);

    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = levels_of(WIDTH);
    localparam int LAT    = lat_of(WIDTH);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("pipelined_tree_multiplier: WIDTH=%0d is not one of 4, 8, 16, 32", WIDTH);
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- stage 0: partial products ----------------
    logic [PW-1:0]              a_ext;
    logic [WIDTH-1:0][PW-1:0]   pp_d;
    logic [WIDTH-1:0][PW-1:0]   pp_q;
    stage_ctl_t                 ctl0_q;

    assign a_ext = in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        logic [PW-1:0] row;
        assign row = b[gi] ? (a_ext << gi) : '0;
        if (gi == WIDTH - 1) begin : g_msb
            // The multiplier's MSB has weight -2^(WIDTH-1) in signed mode.
            assign pp_d[gi] = in_signed ? -row : row;
        end else begin : g_low
            assign pp_d[gi] = row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl0_q <= '0;
        end else if (advance) begin
            ctl0_q.valid <= in_valid;
            ctl0_q.sgn   <= in_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            pp_q <= pp_d;
        end
    end

    // ---------------- adder tree ----------------
    // All levels live in one flat node vector; level k starts at level_offset(k).
    logic [2*WIDTH-2:0][PW-1:0]  node;
    stage_ctl_t [LEVELS:0]       ctl;

    assign node[WIDTH-1:0] = pp_q;
    assign ctl[0]          = ctl0_q;

    for (genvar gi = 1; gi < LAT; gi++) begin : g_level
        localparam int N_IN = WIDTH >> (gi - 1);
        mult_add_level #(
            .PW   (PW),
            .N_IN (N_IN)
        ) u_level (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (advance),
            .ctl_i  (ctl[gi-1]),
            .sums_i (node[level_offset(WIDTH, gi - 1) +: N_IN]),
            .ctl_o  (ctl[gi]),
            .sums_o (node[level_offset(WIDTH, gi) +: N_IN / 2])
        );
    end

    logic [PW-1:0] last_sum;
    assign last_sum = node[2*WIDTH-2];

    // ---------------- output register ----------------
    logic          out_valid_q;
    logic [PW-1:0] product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (advance) begin
            out_valid_q <= ctl[LEVELS].valid;
            if (ctl[LEVELS].valid) begin
                product_q <= last_sum;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

`ifdef MULT_ROUND_EN
    localparam int            RW         = WIDTH + 1;
    localparam logic [PW-1:0] ROUND_HALF = PW'(1) << (WIDTH - 2);

    // Bits [2W-1:W-1] of the rounded product; the top two differ only when the
    // Q(WIDTH-1) result overflows (-1.0 x -1.0).
    logic [RW-1:0]    rnd_hi;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    assign rnd_hi = RW'((last_sum + ROUND_HALF) >> (WIDTH - 1));

    always_comb begin
        q_d = '0;
        if (ctl[LEVELS].sgn) begin
            if (rnd_hi[WIDTH] != rnd_hi[WIDTH-1]) begin
                q_d = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                q_d = rnd_hi[WIDTH-1:0];
            end
        end else begin
            q_d = last_sum[PW-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (advance && ctl[LEVELS].valid) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
`else
    // The signed flag is only consumed by the rounding output.
    logic unused_last_sgn;
    assign unused_last_sgn = ctl[LEVELS].sgn;
`endif

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
module tb_pipelined_tree_multiplier;

    localparam int W   = 16;
    localparam int PW  = 2 * W;
    localparam int LAT = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
`ifdef MULT_ROUND_EN
    logic [W-1:0]  q;
`endif

    always #5 clk = ~clk;

    pipelined_tree_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef MULT_ROUND_EN
        ,
        .q         (q)
`endif
    );

    typedef struct {
        logic [PW-1:0] p;
        logic [W-1:0]  qv;
        int            acc;
    } sb_t;

    sb_t sb[$];
    int  n_compared   = 0;
    int  n_mismatched = 0;
    int  cyc          = 0;
    int  n_out        = 0;
    bit  lat_chk      = 1'b1;
    bit  use_drv      = 1'b0;
    logic [PW-1:0] drv_p = '0;
    logic [W-1:0]  drv_q = '0;

    // Directed vectors with hand-derived expectations.
    localparam logic [W-1:0]  DIR_A [7] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h4000, 16'h8000, 16'h8000, 16'h7FFF};
    localparam logic [W-1:0]  DIR_B [7] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h4000, 16'h8000, 16'h0001, 16'h8000};
    localparam logic          DIR_S [7] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
    localparam logic [PW-1:0] DIR_P [7] = '{32'hFFFE0001, 32'h00000001, 32'h40000000, 32'h10000000,
                                            32'h40000000, 32'hFFFF8000, 32'hC0008000};
    localparam logic [W-1:0]  DIR_Q [7] = '{16'hFFFE, 16'h0000, 16'h7FFF, 16'h2000, 16'h4000, 16'hFFFF, 16'h8001};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint xs, ys, pr;
        if (s) begin
            xs = longint'($signed(x));
            ys = longint'($signed(y));
        end else begin
            xs = longint'(x);
            ys = longint'(y);
        end
        pr = xs * ys;
        return pr[PW-1:0];
    endfunction

    function automatic logic [W-1:0] ref_q(input logic [PW-1:0] p, input logic s);
        longint ps, r, qmax;
        logic [W-1:0] res;
        qmax = (longint'(1) <<< (W - 1)) - 1;
        if (s) begin
            ps = longint'($signed(p));
            r  = (ps + (longint'(1) <<< (W - 2))) >>> (W - 1);
            if (r > qmax) r = qmax;
            res = r[W-1:0];
        end else begin
            res = p[PW-1:W];
        end
        return res;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes are seen at the negedge before the edge that
    // completes them.
    always @(negedge clk) begin : mon
        sb_t e;
        sb_t n;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    check("product", 64'(product), 64'(e.p));
`ifdef MULT_ROUND_EN
                    check("q", 64'(q), 64'(e.qv));
`endif
                    if (lat_chk) check("latency", 64'(cyc - e.acc), 64'(LAT));
                    $display("out #%0d: product=0x%08h expected=0x%08h", n_out, product, e.p);
                end
            end
            if (in_valid && in_ready) begin
                if (use_drv) begin
                    n.p  = drv_p;
                    n.qv = drv_q;
                end else begin
                    n.p  = ref_prod(a, b, in_signed);
                    n.qv = ref_q(n.p, in_signed);
                end
                n.acc = cyc + 1;
                sb.push_back(n);
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        in_valid  = v;
        a         = x;
        b         = y;
        in_signed = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [PW-1:0] held;
        int            out_before;

        in_valid = 1'b0; a = '0; b = '0; in_signed = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        check("out_valid_after_reset", 64'(out_valid), 64'd0);

        // Directed corner cases, back to back.
        use_drv = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drv_p = DIR_P[i];
            drv_q = DIR_Q[i];
            drive(1'b1, DIR_A[i], DIR_B[i], DIR_S[i]);
        end
        use_drv = 1'b0;
        drain("drain_directed");

        // 20 random mixed-mode pairs, back to back.
        out_before = n_out;
        for (int i = 0; i < 20; i++) drive_rand(1'b1);
        drain("drain_stream");
        check("stream_count", 64'(n_out - out_before), 64'd20);

        // Stall with a result waiting at the output.
        lat_chk = 1'b0;
        for (int i = 0; i < 6; i++) drive_rand(1'b1);
        check("stall_pre_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = product;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); in_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_product", 64'(product), 64'(held));
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain("drain_stall");

        // Random back-pressure and bubbles.
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive_rand(1'($urandom_range(0, 1)));
        end
        drain("drain_random_ready");

        // Reset with three transactions in flight.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) drive_rand(1'b1);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_product", 64'(product), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("no_stale_valid", 64'(out_valid), 64'd0);
        drive_rand(1'b1);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
